// File: rtl/mem_responder.sv
// mem_responder
//
// Memory-side responder for the CPU's single-port memory interface. It serves
// one request at a time from word-organised storage and answers after a fixed
// number of cycles set by LATENCY. Used as main memory in simulation and for
// FPGA bring-up.
//
// Parameters:
//   ADDR_BITS - word-address bits; storage holds 2**ADDR_BITS 16-bit words
//   LATENCY   - cycles from request acceptance to mem_resp (1..15)
//
// Ports:
//   clk             - system clock, all state changes on the rising edge
//   rst             - synchronous active-high reset (storage is not cleared)
//   mem_read        - read request, held by the initiator until mem_resp
//   mem_write       - write request, held by the initiator until mem_resp
//   mem_byte_enable - write byte mask, bit0 = [7:0], bit1 = [15:8]
//   mem_address     - byte address; bits [ADDR_BITS:1] select the word
//   mem_wdata       - write data
//   mem_resp        - one-cycle completion pulse
//   mem_rdata       - read data, valid in the mem_resp cycle of a read and
//                     held until the next read response
//   err             - sticky flag: read and write were requested together

module mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic [3:0] count;
  logic [3:0] next_count;

  logic                 accept;
  logic                 abort;
  logic [ADDR_BITS-1:0] req_index;
  logic [ADDR_BITS-1:0] rd_index;
  logic                 rd_op;

  logic [ADDR_BITS-1:0] lat_index;
  logic [15:0]          lat_wdata;
  logic [1:0]           lat_be;
  logic                 lat_write;

  // Storage starts out all zero and is deliberately left alone by reset so
  // that a program image survives a CPU reset.
  logic [15:0] storage [DEPTH] = '{default: 16'h0000};

  // Bit 0 and the bits above the word index are don't-cares; addresses alias.
  logic unused_addr;
  assign unused_addr = ^mem_address;

  assign req_index = mem_address[ADDR_BITS:1];
  assign mem_resp  = (state == RESP);

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // Next-state logic. In BUSY the request line of the accepted operation must
  // stay as it was; a read that drops, or a write line rising under a read,
  // is treated as the initiator withdrawing the request.
  always_comb begin
    next_state = state;
    next_count = count;
    accept     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read | mem_write) begin
          accept     = 1'b1;
          next_count = 4'(LATENCY - 1);
          next_state = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        abort = lat_write ? !mem_write : (!mem_read || mem_write);
        if (abort) begin
          next_state = IDLE;
          next_count = 4'd0;
        end else begin
          next_count = count - 4'd1;
          if (count == 4'd1) begin
            next_state = RESP;
          end
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_count = 4'd0;
      end
    endcase
  end

  // Request capture at acceptance. A simultaneous read+write is executed as a
  // write, so the write line alone decides the operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_index <= '0;
      lat_wdata <= 16'h0000;
      lat_be    <= 2'b00;
      lat_write <= 1'b0;
    end else if (accept) begin
      lat_index <= req_index;
      lat_wdata <= mem_wdata;
      lat_be    <= mem_byte_enable;
      lat_write <= mem_write;
    end
  end

  // Sticky protocol-violation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && mem_read && mem_write) begin
      err <= 1'b1;
    end
  end

  // Read data is loaded on the edge that enters RESP so it is already valid
  // while mem_resp is high. With LATENCY=1 that edge is the acceptance edge,
  // so the live address is used instead of the not-yet-latched one.
  assign rd_index = (state == IDLE) ? req_index : lat_index;
  assign rd_op    = (state == IDLE) ? !mem_write : !lat_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata <= 16'h0000;
    end else if (next_state == RESP && rd_op) begin
      mem_rdata <= storage[rd_index];
    end
  end

  // Writes commit at the end of the RESP cycle, before any later acceptance,
  // so a following read sees the new data. Reset in that cycle cancels it.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && lat_write) begin
      if (lat_be[0]) begin
        storage[lat_index][7:0] <= lat_wdata[7:0];
      end
      if (lat_be[1]) begin
        storage[lat_index][15:8] <= lat_wdata[15:8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//
// Self-checking bench for mem_responder. The main instance runs with
// LATENCY=4; a second instance with LATENCY=1 covers the held-request case.
// Expected responses are pushed to a scoreboard queue when a request is
// issued and popped when the DUT answers.

module tb_mem_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        err;

  logic        read1;
  logic        resp1;
  logic [15:0] rdata1;
  logic        err1;

  typedef struct {
    logic [15:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  bit   sb_resp1[$];

  int checks = 0;
  int errors = 0;

  mem_responder #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .err             (err)
  );

  mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (read1),
    .mem_write       (1'b0),
    .mem_byte_enable (2'b11),
    .mem_address     (16'h0010),
    .mem_wdata       (16'h0000),
    .mem_resp        (resp1),
    .mem_rdata       (rdata1),
    .err             (err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one request at cycle 0 and hold it until mem_resp or a 20-cycle
  // bound. lat is the cycle of mem_resp relative to cycle 0, 0 on timeout.
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [1:0] be,
                         output int lat, output logic [15:0] rdata);
    lat   = 0;
    rdata = 16'h0000;
    @(posedge clk); #1;
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_wdata       = wdata;
    mem_byte_enable = be;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (mem_resp) begin
        lat   = i;
        rdata = mem_rdata;
        break;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic pop_compare(input string name, input int lat, input logic [15:0] rdata);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_sb: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("[TB] FAIL %s_lat: got %0d want %0d", name, lat, e.lat);
    end
    checks++;
    if (rdata !== e.data) begin
      errors++;
      $display("[TB] FAIL %s_rdata: got %h want %h", name, rdata, e.data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem_resp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_resp: got %b want 0", mem_resp);
    end
    checks++;
    if (mem_rdata !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h want 0000", mem_rdata);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_err: got %b want 0", err);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_latency();
    int lat;
    logic [15:0] rd;
    sb.push_back('{data: 16'h0000, lat: LAT});
    run_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, lat, rd);
    pop_compare("read_0010", lat, rd);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_err: got %b want 0", err);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_resp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL resp_one_cycle: got %b want 0", mem_resp);
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [15:0] rd;
    sb.push_back('{data: 16'h0000, lat: LAT});
    run_txn(1'b0, 1'b1, 16'h0020, 16'hBEEF, 2'b11, lat, rd);
    pop_compare("write_beef", lat, rd);
    sb.push_back('{data: 16'hBEEF, lat: LAT});
    run_txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, rd);
    pop_compare("read_0020", lat, rd);
    sb.push_back('{data: 16'hBEEF, lat: LAT});
    run_txn(1'b1, 1'b0, 16'h0021, 16'h0000, 2'b00, lat, rd);
    pop_compare("read_0021", lat, rd);
  endtask

  task automatic test_byte_mask();
    int lat;
    logic [15:0] rd;
    sb.push_back('{data: 16'hBEEF, lat: LAT});
    run_txn(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b01, lat, rd);
    pop_compare("write_be01", lat, rd);
    sb.push_back('{data: 16'hBE34, lat: LAT});
    run_txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, rd);
    pop_compare("read_be01", lat, rd);
    sb.push_back('{data: 16'hBE34, lat: LAT});
    run_txn(1'b0, 1'b1, 16'h0020, 16'h5600, 2'b10, lat, rd);
    pop_compare("write_be10", lat, rd);
    sb.push_back('{data: 16'h5634, lat: LAT});
    run_txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, rd);
    pop_compare("read_be10", lat, rd);
    sb.push_back('{data: 16'h5634, lat: LAT});
    run_txn(1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, lat, rd);
    pop_compare("write_be00", lat, rd);
    sb.push_back('{data: 16'h5634, lat: LAT});
    run_txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, rd);
    pop_compare("read_be00", lat, rd);
  endtask

  task automatic test_abort();
    int lat;
    int resp_seen;
    logic [15:0] rd;
    // Initiator drops mem_write at cycle 2.
    @(posedge clk); #1;
    mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'hAAAA; mem_byte_enable = 2'b11;
    resp_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 2) mem_write = 1'b0;
      if (mem_resp) resp_seen++;
    end
    checks++;
    if (resp_seen !== 0) begin
      errors++;
      $display("[TB] FAIL abort_drop_resp: got %0d pulses want 0", resp_seen);
    end
    sb.push_back('{data: 16'h0000, lat: LAT});
    run_txn(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, lat, rd);
    pop_compare("abort_drop_read", lat, rd);

    // Make mem_rdata non-zero so the reset value is observable.
    sb.push_back('{data: 16'h5634, lat: LAT});
    run_txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, rd);
    pop_compare("pre_reset_read", lat, rd);

    // Reset pulsed at cycle 2 with the write still held.
    @(posedge clk); #1;
    mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'hAAAA; mem_byte_enable = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_write = 1'b0;
    checks++;
    if (mem_resp !== 1'b0 || mem_rdata !== 16'h0000 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_rst_outputs: got resp=%b rdata=%h err=%b want 0 0000 0",
               mem_resp, mem_rdata, err);
    end
    resp_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (mem_resp) resp_seen++;
    end
    checks++;
    if (resp_seen !== 0) begin
      errors++;
      $display("[TB] FAIL abort_rst_resp: got %0d pulses want 0", resp_seen);
    end
    sb.push_back('{data: 16'h0000, lat: LAT});
    run_txn(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, lat, rd);
    pop_compare("abort_rst_read", lat, rd);
  endtask

  task automatic test_read_write_err();
    int lat;
    logic [15:0] rd;
    sb.push_back('{data: 16'h0000, lat: LAT});
    run_txn(1'b1, 1'b1, 16'h0040, 16'h7777, 2'b11, lat, rd);
    pop_compare("rw_both", lat, rd);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rw_err_set: got %b want 1", err);
    end
    sb.push_back('{data: 16'h7777, lat: LAT});
    run_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, lat, rd);
    pop_compare("rw_readback", lat, rd);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rw_err_sticky: got %b want 1", err);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rw_err_cleared: got %b want 0", err);
    end
  endtask

  task automatic test_back_to_back();
    bit want;
    int bad;
    // Held read on the LATENCY=1 instance: response on every second cycle.
    for (int i = 1; i <= 10; i++) sb_resp1.push_back(i % 2 == 1);
    @(posedge clk); #1;
    read1 = 1'b1;
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      want = sb_resp1.pop_front();
      if (resp1 !== want) begin
        bad++;
        $display("[TB] FAIL b2b_resp_c%0d: got %b want %b", i, resp1, want);
      end
    end
    read1 = 1'b0;
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (rdata1 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL b2b_rdata: got %h want 0000", rdata1);
    end
  endtask

  task automatic test_alias();
    int lat;
    logic [15:0] rd;
    sb.push_back('{data: 16'h0000, lat: LAT});
    run_txn(1'b0, 1'b1, 16'h0802, 16'hCAFE, 2'b11, lat, rd);
    pop_compare("alias_write", lat, rd);
    sb.push_back('{data: 16'hCAFE, lat: LAT});
    run_txn(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, lat, rd);
    pop_compare("alias_read", lat, rd);
  endtask

  initial begin
    rst             = 1'b1;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    mem_address     = 16'h0000;
    mem_wdata       = 16'h0000;
    read1           = 1'b0;
    test_reset();
    test_read_latency();
    test_write_read();
    test_byte_mask();
    test_abort();
    test_read_write_err();
    test_back_to_back();
    test_alias();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
